// File: rtl/mem_dump.sv
// mem_dump: walks a word-aligned window of the data BRAM through its debug
// port and streams each word out as four bytes, least-significant first,
// over a valid/ready byte channel. Raises busy for the duration and pulses
// done once when the window has been sent.
module mem_dump #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] dbg_addr_q;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] rem_dec;

  assign rem_dec = remaining_q - ONE;

  // Outputs decode straight from state so reset clears them without an edge.
  assign tx_valid = (state_q == S_SEND);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign tx_data  = word_q[{idx_q, 3'b000} +: 8];
  // The debug address follows cur_addr in READ and otherwise holds its last
  // presented value.
  assign dbg_addr = (state_q == S_READ) ? cur_addr_q : dbg_addr_q;

  // Next-state and datapath updates for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    idx_d       = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          remaining_d = word_count;
          state_d     = (word_count == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        word_d  = dbg_data;
        idx_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (idx_q == 2'd3) begin
            remaining_d = rem_dec;
            if (rem_dec == '0) begin
              state_d = S_FIN;
            end else begin
              cur_addr_d = cur_addr_q + FOUR;
              state_d    = S_READ;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      dbg_addr_q  <= '0;
      word_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      dbg_addr_q  <= dbg_addr;
      word_q      <= word_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// Scoreboard bench for mem_dump: stimulus pushes the expected address, byte
// and word-count streams computed from a flat memory model; monitors pop and
// compare as the DUT presents READ cycles, byte handshakes and done pulses.
module tb_mem_dump;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NW];
  assign dbg_data = mem[dbg_addr[AW-1:2]];

  mem_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int bytes_this_dump = 0;

  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_addr [$];
  int            exp_cnt [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the dump is the word-aligned window starting at base, wrapping
  // the address space, each word emitted least-significant byte first.
  task automatic push_model(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    int a;
    logic [DW-1:0] w;
    for (int i = 0; i < int'(cnt); i++) begin
      a = ((int'(base) / 4) * 4 + 4 * i) % (1 << AW);
      exp_addr.push_back(AW'(a));
      w = mem[a / 4];
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
    exp_cnt.push_back(int'(cnt));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: steady high or random toggling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end
  end

  // Byte / address monitor.
  initial begin
    logic          pv, pr;
    logic [7:0]    pd;
    logic [AW-1:0] last_addr;
    logic [7:0]    eb;
    pv = 0; pr = 0; pd = '0; last_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 0; pr = 0; bytes_this_dump = 0;
      end else begin
        if (busy && !tx_valid && !done) begin
          if (exp_addr.size() == 0) chk("unexpected_read", 64'(dbg_addr), 64'hDEAD);
          else begin
            last_addr = exp_addr.pop_front();
            chk("dbg_addr_read", 64'(dbg_addr), 64'(last_addr));
          end
        end
        if (tx_valid) begin
          chk("dbg_addr_hold", 64'(dbg_addr), 64'(last_addr));
          if (pv && !pr) chk("stall_stable", 64'(tx_data), 64'(pd));
          if (tx_ready) begin
            if (exp_bytes.size() == 0) chk("unexpected_byte", 64'(tx_data), 64'hDEAD);
            else begin
              eb = exp_bytes.pop_front();
              chk("tx_byte", 64'(tx_data), 64'(eb));
            end
            bytes_this_dump++;
          end
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
      end
    end
  end

  // Done monitor: per-dump byte total and, with ready held high, latency.
  initial begin
    logic bprev;
    int rise, n;
    bprev = 0; rise = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bprev = 0;
      end else begin
        if (busy && !bprev) rise = cyc;
        if (done) begin
          chk("done_busy", 64'(busy), 64'd1);
          if (exp_cnt.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            n = exp_cnt.pop_front();
            chk("dump_bytes", 64'(bytes_this_dump), 64'(4 * n));
            if (ready_mode == 0) chk("done_latency", 64'(cyc - rise), 64'(5 * n));
          end
          bytes_this_dump = 0;
        end
        bprev = busy;
      end
    end
  end

  task automatic do_dump(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    @(posedge clk);
    #1;
    start = 1; base_addr = base; word_count = cnt;
    push_model(base, cnt);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 2000) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    mem[0] = 32'h5; mem[1] = 32'h3; mem[2] = 32'h4;

    // Reset state
    #12;
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_dbg_addr", 64'(dbg_addr), 0);
    chk("rst_tx_data", 64'(tx_data), 0);
    @(negedge clk);
    rst = 1;

    // Basic dump, ready held high
    ready_mode = 0;
    do_dump(10'h000, 10'd3);
    wait_done("basic");

    // Backpressure
    ready_mode = 1;
    do_dump(10'h000, 10'd3);
    wait_done("backpressure");

    // Zero count
    ready_mode = 0;
    do_dump(10'h000, 10'd0);
    wait_done("zero");
    @(negedge clk);
    chk("zero_busy_one_cycle", 64'(busy), 0);

    // Wrap and alignment
    do_dump(10'h3FE, 10'd2);
    wait_done("wrap");

    // Ignored start mid-dump, then restart
    do_dump(10'h000, 10'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1; base_addr = 10'h008; word_count = 10'd1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done("ignored_start");
    do_dump(10'h00C, 10'd1);
    wait_done("restart");

    // Start coinciding with done is dropped
    do_dump(10'h010, 10'd1);
    wait_done("pre_fin_start");
    start = 1; base_addr = 10'h020; word_count = 10'd2;
    @(posedge clk);
    #1;
    start = 0;
    chk("start_at_done_ignored", 64'(busy), 0);

    // Reset mid-SEND
    do_dump(10'h000, 10'd3);
    for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_tx_valid", 64'(tx_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_done", 64'(done), 0);
    exp_bytes.delete(); exp_addr.delete(); exp_cnt.delete();
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_outputs", 64'({tx_valid, busy, done, dbg_addr, tx_data}), 0);
    end
    // Release and request in the same cycle: the first edge must take start
    @(posedge clk);
    #1;
    rst = 1; start = 1; base_addr = 10'h00C; word_count = 10'd1;
    push_model(10'h00C, 10'd1);
    @(posedge clk);
    #1;
    start = 0;
    chk("post_rst_start_taken", 64'(busy), 1);
    wait_done("post_rst");

    // Randomized dumps
    for (int t = 0; t < 12; t++) begin
      ready_mode = int'($urandom % 2);
      do_dump(AW'($urandom), AW'($urandom_range(0, 6)));
      wait_done("rand");
    end

    repeat (3) @(negedge clk);
    chk("bytes_drained", 64'(exp_bytes.size()), 0);
    chk("addrs_drained", 64'(exp_addr.size()), 0);
    chk("dones_drained", 64'(exp_cnt.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
